axi4_slave_mem_responder: RTL and testbench
===========================================

Name: axi4_slave_mem_responder

Overview:
AXI4 subordinate (responder) endpoint that terminates one slave port of the 16x16 AXI4 interconnect with a word-addressed on-chip memory. It completes write bursts with a single B response and read bursts with R beats, and flags protocol/range errors with SLVERR. It is used as the RTL target behind interconnect slave ports in VIP+RTL integration runs. Read and write channels operate independently, one outstanding transaction per direction.

Parameters:
DATA_WIDTH, 32, data bus width in bits (power of 2, 32..256)
ADDR_WIDTH, 32, address width in bits
ID_WIDTH, 4, AXI ID width
MEM_DEPTH, 1024, memory depth in DATA_WIDTH words
BASE_ADDR, 0, byte address mapped to word 0

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
awvalid in 1, awready out 1  AW handshake
wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
wvalid in 1, wready out 1  W handshake
bid/bresp  out  ID_WIDTH/2  write response
bvalid out 1, bready in 1  B handshake
arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
arvalid in 1, arready out 1  AR handshake
rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data
rvalid out 1, rready in 1  R handshake

Behaviour:
- Reset (async assert, sync release): all outputs 0 (awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata); FSMs -> IDLE; memory contents untouched (undefined until written). Reset mid-burst drops the burst; beats already written persist, no B/R issued.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. awready=1 only in W_IDLE (rises first cycle after reset release). AW handshake: capture id/addr/len/size/burst, beat count=0, err=0; next cycle wready=1.
- W_DATA: each wvalid&&wready beat writes bytes enabled by wstrb to word (addr-BASE_ADDR)>>log2(DATA_WIDTH/8), then advances addr. Beat awlen+1 ends burst regardless of wlast -> W_RESP, wready=0. err set if wlast!=(beat==awlen) on any beat.
- W_RESP: bvalid=1, bid=captured awid, bresp=SLVERR(2'b10) if err else OKAY(2'b00); held stable until bready; return to W_IDLE next cycle (awready high the cycle after B handshake).
- Read FSM R_IDLE -> R_DATA -> R_IDLE. arready=1 only in R_IDLE. AR handshake: capture fields; rdata registered from memory at that edge; rvalid=1 next cycle. Each rvalid&&rready loads next beat at same edge (full throughput, no bubbles); rlast=1 on beat arlen; after last handshake rvalid=0, return to R_IDLE. rid=arid on all beats. Outputs stable while rvalid&&!rready.
- Address advance, incr=1<<size: FIXED(00) addr unchanged; INCR(01) addr+incr (no 4KB check); WRAP(10) bound=(len+1)*incr, next=(addr & ~(bound-1)) | ((addr+incr)&(bound-1)).
- Errors -> SLVERR for whole write / every read beat of burst, writes suppressed, reads return rdata=0: size > log2(DATA_WIDTH/8); burst=2'b11; WRAP with len not in {1,3,7,15}; WRAP with unaligned addr. Per-beat range error (addr<BASE_ADDR or word index >= MEM_DEPTH): that write beat dropped and burst err set; that read beat rdata=0, rresp=SLVERR, other beats OKAY.
- Narrow transfers: wstrb used as given, no lane check.
- Same-cycle read and write to same word: read sampled at that edge returns old data.
- Unused AXI signals (lock, cache, prot, qos, region, user) not present; EXOKAY never returned.

Test Plan:
- Single write awaddr=0x10 len=0 size=2 wdata=0xDEADBEEF wstrb=0xF, then read 0x10 -> bresp=OKAY, rdata=0xDEADBEEF, rlast=1, rid=arid.
- INCR len=3 from 0x100, data 1..4, bready held 0 for 5 cycles -> bvalid stays high stable; read back 1..4 back-to-back with rready=1, rlast on 4th beat only.
- WRAP len=3 size=2 addr=0x38 write A,B,C,D -> words at 0x38,0x3C,0x30,0x34 hold A,B,C,D; WRAP addr=0x3A -> SLVERR, memory unchanged.
- wstrb=0x3 over 0xFFFFFFFF with wdata=0x12345678 -> reads 0xFFFF5678; wlast asserted on beat 1 of len=3 -> bresp=SLVERR, all 4 beats still consumed.
- Read len=1 straddling MEM_DEPTH end -> beat0 OKAY with data, beat1 rdata=0 rresp=SLVERR; rready toggling 1/0 -> each beat held until accepted.
- aresetn low during beat 2 of INCR len=7 write -> bvalid/wready/rvalid 0 immediately, awready=1 first cycle after release, beats 0-1 retained in memory.

Source files
------------

// File: rtl/axi4_slave_mem_responder_if.sv
// AXI4 bus bundle between an interconnect slave port (master modport drives
// requests) and the memory responder (slave modport answers them).
interface axi4_slave_mem_responder_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // write address
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    // write data
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // write response
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // read address
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    // read data
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 responder backed by a word-addressed on-chip memory. Independent read
// and write FSMs, one outstanding transaction each. Burst-level protocol
// errors and per-beat out-of-range accesses are answered with SLVERR.
module axi4_slave_mem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axi4_slave_mem_responder_if.slave axi
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Whole-burst errors: oversize beat, reserved burst type, illegal WRAP.
    function automatic logic burst_err(input addr_t addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic  e;
        addr_t incr;
        incr = addr_t'(1) << size;
        e    = 1'b0;
        if (int'(size) > OFFS) e = 1'b1;
        if (burst == 2'b11)    e = 1'b1;
        if (burst == 2'b10) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) e = 1'b1;
            if ((addr & (incr - addr_t'(1))) != '0) e = 1'b1;
        end
        return e;
    endfunction

    // Address of the following beat for FIXED / INCR / WRAP bursts.
    function automatic addr_t next_addr(input addr_t addr, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        addr_t incr;
        addr_t bound;
        addr_t nxt;
        incr  = addr_t'(1) << size;
        bound = (addr_t'(len) + addr_t'(1)) << size;
        case (burst)
            2'b01:   nxt = addr + incr;
            2'b10:   nxt = (addr & ~(bound - addr_t'(1))) | ((addr + incr) & (bound - addr_t'(1)));
            default: nxt = addr;
        endcase
        return nxt;
    endfunction

    function automatic logic in_range(input addr_t addr);
        return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> OFFS) < addr_t'(MEM_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input addr_t addr);
        return IDX_W'((addr - BASE_ADDR) >> OFFS);
    endfunction

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_t              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic [ID_WIDTH-1:0]   bid_q,     bid_d;
    addr_t                 waddr_q,   waddr_d;
    logic [7:0]            wlen_q,    wlen_d;
    logic [2:0]            wsize_q,   wsize_d;
    logic [1:0]            wburst_q,  wburst_d;
    logic [7:0]            wbeat_q,   wbeat_d;
    logic                  werr_q,    werr_d;
    logic                  wsupp_q,   wsupp_d;

    logic                  w_last_beat;
    logic                  w_beat_err;
    logic                  aw_err;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;

    // Next-state and datapath for the write FSM, including memory write enable.
    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wsize_d     = wsize_q;
        wburst_d    = wburst_q;
        wbeat_d     = wbeat_q;
        werr_d      = werr_q;
        wsupp_d     = wsupp_q;
        aw_err      = burst_err(axi.awaddr, axi.awlen, axi.awsize, axi.awburst);
        w_last_beat = (wbeat_q == wlen_q);
        w_beat_err  = (axi.wlast != w_last_beat) || !in_range(waddr_q);
        mem_we      = 1'b0;
        mem_widx    = word_idx(waddr_q);
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axi.awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bid_d     = axi.awid;
                    waddr_d   = axi.awaddr;
                    wlen_d    = axi.awlen;
                    wsize_d   = axi.awsize;
                    wburst_d  = axi.awburst;
                    wbeat_d   = 8'd0;
                    werr_d    = aw_err;
                    wsupp_d   = aw_err;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi.wvalid && wready_q) begin
                    mem_we  = !wsupp_q && in_range(waddr_q);
                    werr_d  = werr_q | w_beat_err;
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wbeat_d = wbeat_q + 8'd1;
                    // burst length is set by awlen, not by wlast
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (werr_q | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers; reset drops any burst in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= 8'd0;
            wsize_q   <= 3'd0;
            wburst_q  <= 2'b00;
            wbeat_q   <= 8'd0;
            werr_q    <= 1'b0;
            wsupp_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            wsupp_q   <= wsupp_d;
        end
    end

    // Byte-enabled memory write; contents are not reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi.wstrb[b]) mem[mem_widx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_t              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic                  rlast_q,   rlast_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [ID_WIDTH-1:0]   rid_q,     rid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    addr_t                 raddr_q,   raddr_d;
    logic [7:0]            rlen_q,    rlen_d;
    logic [2:0]            rsize_q,   rsize_d;
    logic [1:0]            rburst_q,  rburst_d;
    logic [7:0]            rbeat_q,   rbeat_d;
    logic                  rsupp_q,   rsupp_d;

    logic                  ar_err;
    addr_t                 rd_addr;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    // Next-state for the read FSM; each beat is loaded from memory at the
    // edge that accepts the previous one, so reads see pre-write contents.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        rsupp_d   = rsupp_q;
        ar_err    = burst_err(axi.araddr, axi.arlen, axi.arsize, axi.arburst);
        rd_addr   = (r_state_q == R_IDLE) ? axi.araddr : raddr_q;
        rd_ok     = !((r_state_q == R_IDLE) ? ar_err : rsupp_q) && in_range(rd_addr);
        rd_word   = mem[word_idx(rd_addr)];
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi.arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rid_d     = axi.arid;
                    rlen_d    = axi.arlen;
                    rsize_d   = axi.arsize;
                    rburst_d  = axi.arburst;
                    rsupp_d   = ar_err;
                    rbeat_d   = 8'd0;
                    raddr_d   = next_addr(axi.araddr, axi.arlen, axi.arsize, axi.arburst);
                    rdata_d   = rd_ok ? rd_word : '0;
                    rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    rlast_d   = (axi.arlen == 8'd0);
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && axi.rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rbeat_d = rbeat_q + 8'd1;
                        raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                        rdata_d = rd_ok ? rd_word : '0;
                        rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers; reset abandons any burst in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= 8'd0;
            rsize_q   <= 3'd0;
            rburst_q  <= 2'b00;
            rbeat_q   <= 8'd0;
            rsupp_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            rsupp_q   <= rsupp_d;
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.bid     = bid_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rlast   = rlast_q;
    assign axi.rresp   = rresp_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Directed bench for axi4_slave_mem_responder: writes, reads back and compares
// against hand-computed values, including error and reset cases.
module tb_axi4_slave_mem_responder;
    logic aclk;
    logic aresetn;

    axi4_slave_mem_responder_if ifc ();

    axi4_slave_mem_responder dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi     (ifc)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    int          rd_gap  [16];

    logic [1:0]  bresp_v;
    logic [3:0]  bid_v;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t;
        ifc.awid = id; ifc.awaddr = addr; ifc.awlen = len; ifc.awsize = size; ifc.awburst = burst;
        ifc.awvalid = 1'b1;
        t = 0;
        while (!ifc.awready && t < 50) begin @(posedge aclk); #1; t++; end
        chk("aw_timeout", 64'(t >= 50), 64'd0);
        @(posedge aclk); #1;
        ifc.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int t;
        ifc.wdata = data; ifc.wstrb = strb; ifc.wlast = last; ifc.wvalid = 1'b1;
        t = 0;
        while (!ifc.wready && t < 50) begin @(posedge aclk); #1; t++; end
        chk("w_timeout", 64'(t >= 50), 64'd0);
        @(posedge aclk); #1;
        ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    endtask

    task automatic b_wait(input int bdelay, output logic [1:0] resp, output logic [3:0] id);
        int t;
        logic stable;
        t = 0;
        while (!ifc.bvalid && t < 50) begin @(posedge aclk); #1; t++; end
        chk("b_timeout", 64'(t >= 50), 64'd0);
        resp = ifc.bresp; id = ifc.bid;
        stable = 1'b1;
        for (int i = 0; i < bdelay; i++) begin
            @(posedge aclk); #1;
            if (!ifc.bvalid || ifc.bresp !== resp || ifc.bid !== id) stable = 1'b0;
        end
        if (bdelay > 0) chk("b_stable_while_stalled", 64'(stable), 64'd1);
        ifc.bready = 1'b1;
        @(posedge aclk); #1;
        ifc.bready = 1'b0;
        chk("b_drop_after_hs", 64'(ifc.bvalid), 64'd0);
        chk("awready_after_b", 64'(ifc.awready), 64'd1);
    endtask

    // wlast_at < 0 means wlast on the true final beat
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int wlast_at, input int bdelay);
        aw_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++)
            w_beat(wbuf[i], sbuf[i], (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at));
        chk("wready_low_after_burst", 64'(ifc.wready), 64'd0);
        b_wait(bdelay, bresp_v, bid_v);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int t;
        logic [31:0] hold;
        ifc.rready = !toggle;
        ifc.arid = id; ifc.araddr = addr; ifc.arlen = len; ifc.arsize = size; ifc.arburst = burst;
        ifc.arvalid = 1'b1;
        t = 0;
        while (!ifc.arready && t < 50) begin @(posedge aclk); #1; t++; end
        chk("ar_timeout", 64'(t >= 50), 64'd0);
        @(posedge aclk); #1;
        ifc.arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!ifc.rvalid && t < 50) begin @(posedge aclk); #1; t++; end
            rd_gap[i] = t;
            if (t >= 50) begin
                chk("r_timeout", 64'd1, 64'd0);
                break;
            end
            if (toggle) begin
                hold = ifc.rdata;
                @(posedge aclk); #1;
                chk("r_hold_valid", 64'(ifc.rvalid), 64'd1);
                chk("r_hold_data", 64'(ifc.rdata), 64'(hold));
                ifc.rready = 1'b1;
            end
            rd_data[i] = ifc.rdata; rd_resp[i] = ifc.rresp;
            rd_last[i] = ifc.rlast; rd_id[i]   = ifc.rid;
            @(posedge aclk); #1;
            if (toggle) ifc.rready = 1'b0;
        end
        ifc.rready = 1'b0;
        chk("rvalid_low_after_burst", 64'(ifc.rvalid), 64'd0);
    endtask

    initial begin
        ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0;
        ifc.awvalid = 1'b0; ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0;
        ifc.bready = 1'b0; ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0;
        ifc.arburst = '0; ifc.arvalid = 1'b0; ifc.rready = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        // reset values
        chk("rst_awready", 64'(ifc.awready), 64'd0);
        chk("rst_arready", 64'(ifc.arready), 64'd0);
        chk("rst_wready",  64'(ifc.wready),  64'd0);
        chk("rst_bvalid",  64'(ifc.bvalid),  64'd0);
        chk("rst_rvalid",  64'(ifc.rvalid),  64'd0);
        chk("rst_rlast",   64'(ifc.rlast),   64'd0);
        chk("rst_resp_id", 64'({ifc.bresp, ifc.rresp, ifc.bid, ifc.rid}), 64'd0);
        chk("rst_rdata",   64'(ifc.rdata),   64'd0);
        aresetn = 1'b1;
        chk("awready_before_edge", 64'(ifc.awready), 64'd0);
        @(posedge aclk); #1;
        chk("awready_after_release", 64'(ifc.awready), 64'd1);
        chk("arready_after_release", 64'(ifc.arready), 64'd1);

        // single-beat write and read back
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, -1, 0);
        chk("single_bresp", 64'(bresp_v), 64'd0);
        chk("single_bid",   64'(bid_v),   64'd3);
        do_read(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("single_rdata", 64'(rd_data[0]), 64'hDEADBEEF);
        chk("single_rlast", 64'(rd_last[0]), 64'd1);
        chk("single_rid",   64'(rd_id[0]),   64'd5);
        chk("single_rresp", 64'(rd_resp[0]), 64'd0);

        // INCR len=3 with stalled B, back-to-back read
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        do_write(4'd7, 32'h100, 8'd3, 3'd2, 2'b01, -1, 5);
        chk("incr_bresp", 64'(bresp_v), 64'd0);
        chk("incr_bid",   64'(bid_v),   64'd7);
        do_read(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", 64'(rd_data[i]), 64'(i + 1));
            chk("incr_rlast", 64'(rd_last[i]), 64'(i == 3));
            chk("incr_gap",   64'(rd_gap[i]),  64'd0);
        end

        // WRAP len=3 from 0x38 lands on 0x38,0x3C,0x30,0x34
        wbuf[0] = 32'hAAAA0000; wbuf[1] = 32'hBBBB1111; wbuf[2] = 32'hCCCC2222; wbuf[3] = 32'hDDDD3333;
        do_write(4'd1, 32'h38, 8'd3, 3'd2, 2'b10, -1, 0);
        chk("wrap_bresp", 64'(bresp_v), 64'd0);
        do_read(4'd1, 32'h30, 8'd3, 3'd2, 2'b01, 1'b0);
        chk("wrap_w30", 64'(rd_data[0]), 64'hCCCC2222);
        chk("wrap_w34", 64'(rd_data[1]), 64'hDDDD3333);
        chk("wrap_w38", 64'(rd_data[2]), 64'hAAAA0000);
        chk("wrap_w3c", 64'(rd_data[3]), 64'hBBBB1111);
        // unaligned WRAP is rejected and leaves memory alone
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5555_0000 + 32'(i);
        do_write(4'd1, 32'h3A, 8'd3, 3'd2, 2'b10, -1, 0);
        chk("wrap_unaligned_bresp", 64'(bresp_v), 64'd2);
        do_read(4'd1, 32'h30, 8'd3, 3'd2, 2'b01, 1'b0);
        chk("wrap_keep_w30", 64'(rd_data[0]), 64'hCCCC2222);
        chk("wrap_keep_w34", 64'(rd_data[1]), 64'hDDDD3333);
        chk("wrap_keep_w38", 64'(rd_data[2]), 64'hAAAA0000);
        chk("wrap_keep_w3c", 64'(rd_data[3]), 64'hBBBB1111);

        // partial strobe merge
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        do_write(4'd0, 32'h80, 8'd0, 3'd2, 2'b01, -1, 0);
        wbuf[0] = 32'h12345678; sbuf[0] = 4'h3;
        do_write(4'd0, 32'h80, 8'd0, 3'd2, 2'b01, -1, 0);
        do_read(4'd0, 32'h80, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("strobe_merge", 64'(rd_data[0]), 64'hFFFF5678);

        // early wlast: all four beats consumed, SLVERR
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h9000 + 32'(i); sbuf[i] = 4'hF; end
        do_write(4'd4, 32'h90, 8'd3, 3'd2, 2'b01, 1, 0);
        chk("early_wlast_bresp", 64'(bresp_v), 64'd2);

        // reserved burst type on read
        do_read(4'd6, 32'h10, 8'd0, 3'd2, 2'b11, 1'b0);
        chk("rsvd_burst_rresp", 64'(rd_resp[0]), 64'd2);
        chk("rsvd_burst_rdata", 64'(rd_data[0]), 64'd0);

        // read straddling the top of memory, rready toggling
        wbuf[0] = 32'h600DF00D; sbuf[0] = 4'hF;
        do_write(4'd0, 32'hFFC, 8'd0, 3'd2, 2'b01, -1, 0);
        do_read(4'd9, 32'hFFC, 8'd1, 3'd2, 2'b01, 1'b1);
        chk("edge_b0_data", 64'(rd_data[0]), 64'h600DF00D);
        chk("edge_b0_resp", 64'(rd_resp[0]), 64'd0);
        chk("edge_b0_last", 64'(rd_last[0]), 64'd0);
        chk("edge_b1_data", 64'(rd_data[1]), 64'd0);
        chk("edge_b1_resp", 64'(rd_resp[1]), 64'd2);
        chk("edge_b1_last", 64'(rd_last[1]), 64'd1);
        chk("edge_rid",     64'(rd_id[1]),   64'd9);

        // reset during beat 2 of INCR len=7
        aw_send(4'd1, 32'h200, 8'd7, 3'd2, 2'b01);
        w_beat(32'h11, 4'hF, 1'b0);
        w_beat(32'h22, 4'hF, 1'b0);
        ifc.wdata = 32'h33; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1;
        chk("mid_wready", 64'(ifc.wready), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_wready",  64'(ifc.wready),  64'd0);
        chk("mid_rst_bvalid",  64'(ifc.bvalid),  64'd0);
        chk("mid_rst_rvalid",  64'(ifc.rvalid),  64'd0);
        chk("mid_rst_awready", 64'(ifc.awready), 64'd0);
        @(posedge aclk); #1;
        ifc.wvalid = 1'b0;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("mid_awready_after_release", 64'(ifc.awready), 64'd1);
        do_read(4'd8, 32'h200, 8'd1, 3'd2, 2'b01, 1'b0);
        chk("mid_keep_b0", 64'(rd_data[0]), 64'h11);
        chk("mid_keep_b1", 64'(rd_data[1]), 64'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
